// File: rtl/pdm_pkg.sv
// Shared types and defaults for the PDM capture block.
package pdm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } pdm_state_e;

  localparam int PDM_DATA_W = 32;
  localparam int PDM_ADDR_W = 12;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pdm_sample_div.sv
// Clock divider producing a one-cycle PDM sample tick every SAMPLE_DIV cycles.
module pdm_sample_div
  import pdm_pkg::*;
#(
  parameter int SAMPLE_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_width(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_r;

  assign tick = en && (cnt_r == LAST);

  // Divider count, restarted at the beginning of every capture session.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      cnt_r <= (cnt_r == LAST) ? {CW{1'b0}} : cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/pdm_control.sv
// PDM microphone capture: packs the bit stream into DATA_W-bit words and writes them to RAM.
// Build option PDM_CONTINUOUS_EN turns the one-shot session into a ring buffer stopped by enable.
module pdm_control
  import pdm_pkg::*;
#(
  parameter int DATA_W     = PDM_DATA_W,
  parameter int ADDR_W     = PDM_ADDR_W,
  parameter int NUM_WORDS  = 4096,
  parameter int SAMPLE_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              micData,
  input  logic              enable,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr
);

  localparam int BW = cnt_width(DATA_W);
  localparam logic [BW-1:0]     LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

  pdm_state_e        state_r;
  logic [DATA_W-1:0] sreg_r;
  logic [BW-1:0]     bit_cnt_r;
  logic [ADDR_W-1:0] word_cnt_r;
  logic              start_s;
  logic              capt_s;
  logic              stop_s;
  logic              tick_s;

  assign start_s = (state_r == IDLE) && enable;
  assign capt_s  = (state_r == CAPTURE);
`ifdef PDM_CONTINUOUS_EN
  assign stop_s  = capt_s && enable;
`else
  assign stop_s  = 1'b0;
`endif

  pdm_sample_div #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .clr (start_s),
    .en  (capt_s),
    .tick(tick_s)
  );

  // Session FSM with shift register, bit/word counters and the registered RAM port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      sreg_r     <= {DATA_W{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      word_cnt_r <= {ADDR_W{1'b0}};
      ram_wr     <= 1'b0;
      ram_data   <= {DATA_W{1'b0}};
      ram_addr   <= {ADDR_W{1'b0}};
    end else begin
      ram_wr <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r    <= CAPTURE;
            bit_cnt_r  <= {BW{1'b0}};
            word_cnt_r <= {ADDR_W{1'b0}};
          end
        end
        CAPTURE: begin
          if (stop_s) begin
            state_r <= IDLE;
          end else begin
            // ram_wr still high means the previous edge wrote a word.
            if (ram_wr) begin
              if (word_cnt_r == LAST_WORD) begin
`ifdef PDM_CONTINUOUS_EN
                word_cnt_r <= {ADDR_W{1'b0}};
`else
                state_r    <= IDLE;
`endif
              end else begin
                word_cnt_r <= word_cnt_r + ADDR_W'(1);
              end
            end
            if (tick_s) begin
              sreg_r <= {sreg_r[DATA_W-2:0], micData};
              if (bit_cnt_r == LAST_BIT) begin
                bit_cnt_r <= {BW{1'b0}};
                ram_data  <= {sreg_r[DATA_W-2:0], micData};
                ram_addr  <= word_cnt_r;
                ram_wr    <= 1'b1;
              end else begin
                bit_cnt_r <= bit_cnt_r + BW'(1);
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_control.sv
// Bench for pdm_control: three parameterisations, a timing-level reference model and a vector table.
module tb_pdm_control;

  localparam int NI   = 3;
  localparam int MAXC = 16384;

  logic clk;
  logic rst;
  logic micData;
  logic enable;
  logic [2:0]       wr_v;
  logic [2:0][31:0] data_v;
  logic [2:0][11:0] addr_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pdm_control u_a (
    .clk(clk), .rst(rst), .micData(micData), .enable(enable),
    .ram_wr(wr_v[0]), .ram_data(data_v[0]), .ram_addr(addr_v[0])
  );
  pdm_control #(.NUM_WORDS(4)) u_b (
    .clk(clk), .rst(rst), .micData(micData), .enable(enable),
    .ram_wr(wr_v[1]), .ram_data(data_v[1]), .ram_addr(addr_v[1])
  );
  pdm_control #(.NUM_WORDS(4), .SAMPLE_DIV(4)) u_c (
    .clk(clk), .rst(rst), .micData(micData), .enable(enable),
    .ram_wr(wr_v[2]), .ram_data(data_v[2]), .ram_addr(addr_v[2])
  );

  int num_w [NI] = '{4096, 4, 4};
  int div_w [NI] = '{1, 1, 4};

  bit          hist_mic [MAXC];
  bit          hist_en  [MAXC];
  bit          log_wr   [NI][MAXC];
  logic [31:0] log_data [NI][MAXC];
  logic [11:0] log_addr [NI][MAXC];

  // Reference model: session start edge per instance; writes land every 32*DIV edges.
  bit          m_on   [NI];
  int          m_s    [NI];
  bit          e_wr   [NI];
  logic [31:0] e_data [NI];
  logic [11:0] e_addr [NI];

  int cyc;
  int n_chk;
  int n_pass;
  int base [3];

  typedef struct {
    string       name;
    int          inst;
    int          sc;
    int          off;
    bit          wr;
    logic [31:0] data;
    logic [11:0] addr;
  } vec_t;
  vec_t tab[$];

  function automatic void add(input string name, input int inst, input int sc, input int off,
                              input bit wr, input logic [31:0] data, input logic [11:0] addr);
    vec_t v;
    v.name = name; v.inst = inst; v.sc = sc; v.off = off;
    v.wr = wr; v.data = data; v.addr = addr;
    tab.push_back(v);
  endfunction

  task automatic chk_vals(input string name, input int i,
                          input bit wr_q, input logic [31:0] d_q, input logic [11:0] a_q,
                          input bit wr_a, input logic [31:0] d_a, input logic [11:0] a_a);
    n_chk++;
    if (wr_a === wr_q && d_a === d_q && a_a === a_q) begin
      n_pass++;
    end else begin
      $display("FAIL %s inst%0d cyc%0d: got wr=%0b data=%h addr=%0d, expected wr=%0b data=%h addr=%0d",
               name, i, cyc, wr_a, d_a, a_a, wr_q, d_q, a_q);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_on[i] = 1'b0; m_s[i] = 0; e_wr[i] = 1'b0;
      e_data[i] = 32'h0; e_addr[i] = 12'h0;
    end
  endtask

  task automatic model_edge(input int c);
    for (int i = 0; i < NI; i++) begin
      int  period;
      bit  active;
      period = 32 * div_w[i];
`ifdef PDM_CONTINUOUS_EN
      active = m_on[i];
`else
      active = m_on[i] && ((c - m_s[i]) <= num_w[i] * period + 1);
`endif
      e_wr[i] = 1'b0;
      if (!active) begin
        if (hist_en[c]) begin
          m_on[i] = 1'b1;
          m_s[i]  = c;
        end
`ifdef PDM_CONTINUOUS_EN
      end else if (hist_en[c]) begin
        m_on[i] = 1'b0;
`endif
      end else if ((c - m_s[i]) % period == 0) begin
        int w;
        logic [31:0] d;
        w = (c - m_s[i]) / period - 1;
        for (int j = 0; j < 32; j++) d[31-j] = hist_mic[m_s[i] + (w * 32 + j + 1) * div_w[i]];
        e_wr[i]   = 1'b1;
        e_data[i] = d;
        e_addr[i] = 12'(w % num_w[i]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    hist_mic[cyc] = micData;
    hist_en[cyc]  = enable;
    #1;
    if (rst) model_edge(cyc);
    else     model_reset();
    for (int i = 0; i < NI; i++) begin
      chk_vals("model", i, e_wr[i], e_data[i], e_addr[i], wr_v[i], data_v[i], addr_v[i]);
      log_wr[i][cyc]   = wr_v[i];
      log_data[i][cyc] = data_v[i];
      log_addr[i][cyc] = addr_v[i];
    end
    if (cyc < MAXC - 1) cyc++;
    else begin
      $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    model_reset();
    repeat (n) step();
    rst = 1'b1;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; micData = 1'b0; enable = 1'b0;
    cyc = 0; n_chk = 0; n_pass = 0;
    model_reset();

    // Scenario 1: constant-one stream; scenario 2: alternating then zero stream.
    add("a_pre",    0, 0, 31,  1'b0, 32'h0000_0000, 12'd0);
    add("a_first",  0, 0, 32,  1'b1, 32'hFFFF_FFFF, 12'd0);
    add("a_hold",   0, 0, 33,  1'b0, 32'hFFFF_FFFF, 12'd0);
    add("a_second", 0, 0, 64,  1'b1, 32'hFFFF_FFFF, 12'd1);
    add("b_last",   1, 0, 128, 1'b1, 32'hFFFF_FFFF, 12'd3);
    add("c_pre",    2, 0, 127, 1'b0, 32'h0000_0000, 12'd0);
    add("c_first",  2, 0, 128, 1'b1, 32'hFFFF_FFFF, 12'd0);
    add("c_second", 2, 0, 256, 1'b1, 32'hFFFF_FFFF, 12'd1);
`ifdef PDM_CONTINUOUS_EN
    add("b_wrap",   1, 0, 160, 1'b1, 32'hFFFF_FFFF, 12'd0);
    add("b_rerun",  1, 0, 2034, 1'b1, 32'hFFFF_FFFF, 12'd0);
    add("b_rerun3", 1, 0, 2130, 1'b1, 32'hFFFF_FFFF, 12'd3);
`else
    add("b_after",  1, 0, 160, 1'b0, 32'hFFFF_FFFF, 12'd3);
    add("b_rerun",  1, 0, 2032, 1'b1, 32'hFFFF_FFFF, 12'd0);
    add("b_rerun3", 1, 0, 2128, 1'b1, 32'hFFFF_FFFF, 12'd3);
    add("a_155",    0, 0, 4992, 1'b1, 32'hFFFF_FFFF, 12'd155);
`endif
    add("alt_w0",   0, 1, 32,  1'b1, 32'hAAAA_AAAA, 12'd0);
    add("alt_w1",   0, 1, 64,  1'b1, 32'hAAAA_AAAA, 12'd1);
    add("zero_w2",  0, 1, 96,  1'b1, 32'h0000_0000, 12'd2);
    add("zero_hold",0, 1, 97,  1'b0, 32'h0000_0000, 12'd2);
    add("b_alt_w3", 1, 1, 128, 1'b1, 32'h0000_0000, 12'd3);

    #3 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++)
      chk_vals("reset_state", i, 1'b0, 32'h0, 12'h0, wr_v[i], data_v[i], addr_v[i]);
    repeat (3) step();
    rst = 1'b1;
    step(); step();

    micData = 1'b1; enable = 1'b1; base[0] = cyc; step(); enable = 1'b0;
    for (int k = 1; k <= 5000; k++) begin
      enable = (k == 2000) || (k == 2002);
      step();
    end
    enable = 1'b0;
`ifndef PDM_CONTINUOUS_EN
    for (int i = 0; i < NI; i++) begin
      cnt = 0;
      for (int c = base[0] + 1; c <= base[0] + 5000; c++) cnt += int'(log_wr[i][c]);
      chk_int($sformatf("write_count_inst%0d", i), cnt, (i == 0) ? 156 : 8);
    end
`endif

    do_reset(2); step();
    base[1] = cyc; enable = 1'b1; micData = 1'b0; step(); enable = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      micData = (k <= 64) ? k[0] : 1'b0;
`ifndef PDM_CONTINUOUS_EN
      enable = (k == 50) || (k >= 60 && k <= 80);
`endif
      step();
    end
    enable = 1'b0;

    // Reset abort after 20 sampled bits of a fresh session.
    enable = 1'b1; micData = 1'($urandom); step(); enable = 1'b0;
    repeat (20) begin micData = 1'($urandom); step(); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++)
      chk_vals("reset_abort", i, 1'b0, 32'h0, 12'h0, wr_v[i], data_v[i], addr_v[i]);
    step(); step();
    rst = 1'b1;
    repeat (40) begin micData = 1'($urandom); step(); end
    enable = 1'b1; step(); enable = 1'b0;
    repeat (32) begin micData = 1'($urandom); step(); end
    chk_vals("restart_addr0", 0, 1'b1, e_data[0], 12'd0, wr_v[0], data_v[0], addr_v[0]);

    repeat (3000) begin
      micData = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 199) == 0);
      step();
    end
    enable = 1'b0;

    foreach (tab[t]) begin
      int idx;
      idx = base[tab[t].sc] + tab[t].off;
      chk_vals(tab[t].name, tab[t].inst, tab[t].wr, tab[t].data, tab[t].addr,
               log_wr[tab[t].inst][idx], log_data[tab[t].inst][idx], log_addr[tab[t].inst][idx]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
